// File: rtl/alu_pkg.sv
// Opcode constants and issue-controller state encoding.
// Shared by the ALU and by alu_issue_ctrl.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MAC  = 4'b0010;
  localparam logic [3:0] OP_MATT = 4'b1001;

  // A matrix-transpose group is eight back-to-back MATT issues.
  localparam logic [2:0] GROUP_LAST = 3'd7;
  localparam logic [3:0] GROUP_SIZE = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } issue_state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command, ALU-side and result-side signals of alu_issue_ctrl.
// master = environment/ALU side, slave = the controller.
interface alu_issue_ctrl_if #(
  parameter int INST_W = 4,
  parameter int DATA_W = 16
);
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [INST_W-1:0] i_cmd_inst;
  logic [DATA_W-1:0] i_cmd_a;
  logic [DATA_W-1:0] i_cmd_b;
  logic              i_start;
  logic              o_in_valid;
  logic              i_busy;
  logic [INST_W-1:0] o_inst;
  logic [DATA_W-1:0] o_data_a;
  logic [DATA_W-1:0] o_data_b;
  logic              i_out_valid;
  logic [DATA_W-1:0] i_data;
  logic              o_res_valid;
  logic              i_res_ready;
  logic [INST_W-1:0] o_res_inst;
  logic [DATA_W-1:0] o_res_data;
  logic              o_done;
  logic              o_err;

  modport master (
    output i_cmd_valid, i_cmd_inst, i_cmd_a, i_cmd_b, i_start,
           i_busy, i_out_valid, i_data, i_res_ready,
    input  o_cmd_ready, o_in_valid, o_inst, o_data_a, o_data_b,
           o_res_valid, o_res_inst, o_res_data, o_done, o_err
  );

  modport slave (
    input  i_cmd_valid, i_cmd_inst, i_cmd_a, i_cmd_b, i_start,
           i_busy, i_out_valid, i_data, i_res_ready,
    output o_cmd_ready, o_in_valid, o_inst, o_data_a, o_data_b,
           o_res_valid, o_res_inst, o_res_data, o_done, o_err
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a pop frees the slot so a same-cycle push on full succeeds.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);
      if (do_pop)  rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Drains queued ALU commands into the ALU and collects tagged results.
//   state | meaning
//   IDLE  | holding commands, waiting for i_start
//   ISSUE | presenting the command head to the ALU while the issue gate passes
//   WAIT  | results outstanding, nothing issuable
//   DONE  | one-cycle o_done pulse, then back to IDLE
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int INST_W    = 4,
  parameter int DATA_W    = 16,
  parameter int CMD_DEPTH = 8,
  parameter int RES_DEPTH = 8,
  parameter int TIMEOUT   = 16
) (
  input logic             i_clk,
  input logic             i_rst_n,
  alu_issue_ctrl_if.slave bus
);
  localparam int CMD_W = INST_W + 2 * DATA_W;
  localparam int RES_W = INST_W + DATA_W;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [CMD_W-1:0]  cmd_head;
  logic              cmd_full;
  logic              cmd_empty;
  logic              cmd_push;
  logic [RES_W-1:0]  res_head;
  logic              res_full;
  logic              res_empty;
  logic              res_pop;
  logic [INST_W-1:0] head_inst;
  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;

  issue_state_t      state;
  logic [2:0]        grp;
  logic [3:0]        outstanding;
  logic [TMR_W-1:0]  tmr;
  logic [INST_W-1:0] last_inst;
  logic              done_r;
  logic              err_r;

  logic              head_matt;
  logic              issue;
  logic              res_accept;
  logic              tmo;
  logic              drained;

  assign cmd_push = bus.i_cmd_valid && !cmd_full;
  assign res_pop  = bus.i_res_ready && !res_empty;

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (cmd_push),
    .wdata   ({bus.i_cmd_inst, bus.i_cmd_a, bus.i_cmd_b}),
    .pop     (issue),
    .rdata   (cmd_head),
    .full    (cmd_full),
    .empty   (cmd_empty)
  );

  sync_fifo #(.WIDTH(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (res_accept),
    .wdata   ({last_inst, bus.i_data}),
    .pop     (res_pop),
    .rdata   (res_head),
    .full    (res_full),
    .empty   (res_empty)
  );

  assign {head_inst, head_a, head_b} = cmd_head;
  assign head_matt = (head_inst == INST_W'(OP_MATT));

  // First MATT of a group needs a drained result FIFO to hold all eight results;
  // the rest of the group streams in without waiting.
  always_comb begin
    issue = 1'b0;
    if (state == ST_ISSUE && !cmd_empty && !bus.i_busy) begin
      if (!head_matt)      issue = (outstanding == 4'd0) && !res_full;
      else if (grp == 3'd0) issue = (outstanding == 4'd0) && res_empty;
      else                  issue = 1'b1;
    end
  end

  assign res_accept = bus.i_out_valid && (outstanding != 4'd0);
  assign tmo        = (outstanding != 4'd0) && !res_accept && (tmr == '0);
  assign drained    = cmd_empty && (outstanding == 4'd0) && (grp == 3'd0);

  assign bus.o_cmd_ready = !cmd_full;
  assign bus.o_in_valid  = issue;
  assign bus.o_inst      = cmd_empty ? '0 : head_inst;
  assign bus.o_data_a    = cmd_empty ? '0 : head_a;
  assign bus.o_data_b    = cmd_empty ? '0 : head_b;
  assign bus.o_res_valid = !res_empty;
  assign bus.o_res_inst  = res_empty ? '0 : res_head[RES_W-1:DATA_W];
  assign bus.o_res_data  = res_empty ? '0 : res_head[DATA_W-1:0];
  assign bus.o_done      = done_r;
  assign bus.o_err       = err_r;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      outstanding <= 4'd0;
      grp         <= 3'd0;
      tmr         <= TMR_W'(TIMEOUT - 1);
      last_inst   <= '0;
    end else begin
      if (tmo)
        outstanding <= 4'd0;
      else if (issue && !head_matt)
        outstanding <= 4'd1;
      else if (issue && grp == GROUP_LAST)
        outstanding <= GROUP_SIZE;
      else if (res_accept)
        outstanding <= outstanding - 4'd1;

      if (tmo)                    grp <= 3'd0;
      else if (issue && head_matt) grp <= grp + 3'd1;

      // Down-counter reloads while idle or on each result; expiry is the zero compare.
      if (outstanding == 4'd0 || res_accept) tmr <= TMR_W'(TIMEOUT - 1);
      else if (tmr != '0)                    tmr <= tmr - TMR_W'(1);

      if (issue) last_inst <= head_inst;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_IDLE;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            err_r  <= 1'b0;
            done_r <= cmd_empty;
            state  <= cmd_empty ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (tmo) begin
            err_r  <= 1'b1;
            done_r <= 1'b1;
            state  <= ST_DONE;
          end else if (drained) begin
            done_r <= 1'b1;
            state  <= ST_DONE;
          end else if (state == ST_ISSUE && outstanding != 4'd0 && !issue) begin
            state <= ST_WAIT;
          end else if (state == ST_WAIT && outstanding == 4'd0 &&
                       (!cmd_empty || grp != 3'd0)) begin
            state <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          done_r <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          done_r <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; the bench plays the ALU and the result consumer.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_issue_ctrl_if #(.INST_W(4), .DATA_W(16)) bus ();

  alu_issue_ctrl #(
    .INST_W(4), .DATA_W(16), .CMD_DEPTH(8), .RES_DEPTH(8), .TIMEOUT(16)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_idle();
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_inst  = '0;
    bus.i_cmd_a     = '0;
    bus.i_cmd_b     = '0;
    bus.i_start     = 1'b0;
    bus.i_busy      = 1'b0;
    bus.i_out_valid = 1'b0;
    bus.i_data      = '0;
    bus.i_res_ready = 1'b0;
  endtask

  task automatic push_cmd(input logic [3:0] inst, input logic [15:0] a, input logic [15:0] b);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_inst  = inst;
    bus.i_cmd_a     = a;
    bus.i_cmd_b     = b;
    step();
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
  endtask

  task automatic respond(input logic [15:0] data);
    bus.i_out_valid = 1'b1;
    bus.i_data      = data;
    step();
    bus.i_out_valid = 1'b0;
  endtask

  task automatic pop_res(output logic v, output logic [3:0] inst, output logic [15:0] data);
    v    = bus.o_res_valid;
    inst = bus.o_res_inst;
    data = bus.o_res_data;
    bus.i_res_ready = 1'b1;
    step();
    bus.i_res_ready = 1'b0;
  endtask

  // Returns with the issue pending on the next rising edge.
  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (bus.o_in_valid && !bus.i_busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.o_done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (seen) step();
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (bus.o_in_valid !== 1'b0)   begin n_bad++; $display("FAIL rst_in_valid: got %b want 0", bus.o_in_valid); end
    n_cmp++; if (bus.o_res_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_res_valid: got %b want 0", bus.o_res_valid); end
    n_cmp++; if (bus.o_done !== 1'b0)       begin n_bad++; $display("FAIL rst_done: got %b want 0", bus.o_done); end
    n_cmp++; if (bus.o_err !== 1'b0)        begin n_bad++; $display("FAIL rst_err: got %b want 0", bus.o_err); end
    n_cmp++; if (bus.o_cmd_ready !== 1'b1)  begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 1", bus.o_cmd_ready); end
    n_cmp++; if (bus.o_inst !== 4'h0)       begin n_bad++; $display("FAIL rst_inst: got %h want 0", bus.o_inst); end
    n_cmp++; if (bus.o_data_a !== 16'h0)    begin n_bad++; $display("FAIL rst_data_a: got %h want 0", bus.o_data_a); end
    n_cmp++; if (bus.o_data_b !== 16'h0)    begin n_bad++; $display("FAIL rst_data_b: got %h want 0", bus.o_data_b); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (dut.state !== ST_IDLE)     begin n_bad++; $display("FAIL rst_state: got %0d want %0d", dut.state, ST_IDLE); end
  endtask

  task automatic test_add();
    logic v; logic [3:0] ri; logic [15:0] rd; bit seen;
    push_cmd(OP_ADD, 16'h0400, 16'h0800);
    pulse_start();
    n_cmp++; if (bus.o_in_valid !== 1'b1)  begin n_bad++; $display("FAIL add_in_valid: got %b want 1", bus.o_in_valid); end
    n_cmp++; if (bus.o_inst !== OP_ADD)    begin n_bad++; $display("FAIL add_inst: got %h want %h", bus.o_inst, OP_ADD); end
    n_cmp++; if (bus.o_data_a !== 16'h0400) begin n_bad++; $display("FAIL add_data_a: got %h want 0400", bus.o_data_a); end
    n_cmp++; if (bus.o_data_b !== 16'h0800) begin n_bad++; $display("FAIL add_data_b: got %h want 0800", bus.o_data_b); end
    step();
    n_cmp++; if (bus.o_in_valid !== 1'b0)  begin n_bad++; $display("FAIL add_single_issue: got %b want 0", bus.o_in_valid); end
    respond(16'h0C00);
    n_cmp++; if (bus.o_res_valid !== 1'b1) begin n_bad++; $display("FAIL add_res_valid: got %b want 1", bus.o_res_valid); end
    n_cmp++; if (bus.o_res_inst !== OP_ADD) begin n_bad++; $display("FAIL add_res_inst: got %h want %h", bus.o_res_inst, OP_ADD); end
    n_cmp++; if (bus.o_res_data !== 16'h0C00) begin n_bad++; $display("FAIL add_res_data: got %h want 0C00", bus.o_res_data); end
    wait_done(seen);
    n_cmp++; if (seen !== 1'b1)            begin n_bad++; $display("FAIL add_done: got %b want 1", seen); end
    pop_res(v, ri, rd);
    n_cmp++; if (bus.o_res_valid !== 1'b0) begin n_bad++; $display("FAIL add_res_drained: got %b want 0", bus.o_res_valid); end
  endtask

  task automatic test_matt_group();
    logic v; logic [3:0] ri; logic [15:0] rd; bit ok; bit seen;
    int good_issues = 0; int extra = 0; int bad_res = 0;
    for (int k = 0; k < 8; k++) push_cmd(OP_MATT, 16'(k), 16'(k + 16));
    n_cmp++; if (bus.o_cmd_ready !== 1'b0) begin n_bad++; $display("FAIL matt_cmd_full: got %b want 0", bus.o_cmd_ready); end
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      wait_issue(ok);
      if (ok && bus.o_inst === OP_MATT && bus.o_data_a === 16'(k) && bus.o_data_b === 16'(k + 16))
        good_issues++;
      step();
    end
    n_cmp++; if (good_issues !== 8)        begin n_bad++; $display("FAIL matt_issues: got %0d want 8", good_issues); end
    for (int k = 0; k < 8; k++) begin
      if (bus.o_in_valid) extra++;
      respond(16'hA000 + 16'(k));
    end
    n_cmp++; if (extra !== 0)              begin n_bad++; $display("FAIL matt_extra_issue: got %0d want 0", extra); end
    wait_done(seen);
    n_cmp++; if (seen !== 1'b1)            begin n_bad++; $display("FAIL matt_done: got %b want 1", seen); end
    n_cmp++; if (dut.outstanding !== 4'd0) begin n_bad++; $display("FAIL matt_outstanding: got %0d want 0", dut.outstanding); end
    for (int k = 0; k < 8; k++) begin
      pop_res(v, ri, rd);
      if (v !== 1'b1 || ri !== OP_MATT || rd !== 16'hA000 + 16'(k)) bad_res++;
    end
    n_cmp++; if (bad_res !== 0)            begin n_bad++; $display("FAIL matt_results: got %0d bad entries want 0", bad_res); end
    n_cmp++; if (bus.o_res_valid !== 1'b0) begin n_bad++; $display("FAIL matt_res_drained: got %b want 0", bus.o_res_valid); end
  endtask

  task automatic test_busy();
    logic v; logic [3:0] ri; logic [15:0] rd; bit seen; int leaks = 0;
    bus.i_busy = 1'b1;
    push_cmd(OP_ADD, 16'h0001, 16'h0002);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.o_in_valid !== 1'b0) leaks++;
      step();
    end
    n_cmp++; if (leaks !== 0)              begin n_bad++; $display("FAIL busy_no_issue: got %0d issues want 0", leaks); end
    n_cmp++; if (bus.o_data_a !== 16'h0001) begin n_bad++; $display("FAIL busy_retained: got %h want 0001", bus.o_data_a); end
    bus.i_busy = 1'b0;
    #1;
    n_cmp++; if (bus.o_in_valid !== 1'b1)  begin n_bad++; $display("FAIL busy_release_issue: got %b want 1", bus.o_in_valid); end
    step();
    respond(16'h0003);
    wait_done(seen);
    n_cmp++; if (seen !== 1'b1)            begin n_bad++; $display("FAIL busy_done: got %b want 1", seen); end
    pop_res(v, ri, rd);
    n_cmp++; if (v !== 1'b1 || ri !== OP_ADD || rd !== 16'h0003) begin n_bad++; $display("FAIL busy_result: got v=%b inst=%h data=%h want 1/0/0003", v, ri, rd); end
  endtask

  task automatic test_timeout();
    push_cmd(OP_ADD, 16'h0005, 16'h0006);
    pulse_start();
    n_cmp++; if (bus.o_in_valid !== 1'b1)  begin n_bad++; $display("FAIL tmo_issue: got %b want 1", bus.o_in_valid); end
    step();
    repeat (15) step();
    n_cmp++; if (bus.o_err !== 1'b0)       begin n_bad++; $display("FAIL tmo_err_early: got %b want 0", bus.o_err); end
    step();
    n_cmp++; if (bus.o_err !== 1'b1)       begin n_bad++; $display("FAIL tmo_err_set: got %b want 1", bus.o_err); end
    n_cmp++; if (bus.o_done !== 1'b1)      begin n_bad++; $display("FAIL tmo_done: got %b want 1", bus.o_done); end
    step();
    n_cmp++; if (bus.o_done !== 1'b0)      begin n_bad++; $display("FAIL tmo_done_width: got %b want 0", bus.o_done); end
    n_cmp++; if (dut.state !== ST_IDLE)    begin n_bad++; $display("FAIL tmo_state: got %0d want %0d", dut.state, ST_IDLE); end
    n_cmp++; if (bus.o_err !== 1'b1)       begin n_bad++; $display("FAIL tmo_err_sticky: got %b want 1", bus.o_err); end
    respond(16'hDEAD);
    n_cmp++; if (bus.o_res_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_late_ignored: got %b want 0", bus.o_res_valid); end
    pulse_start();
    n_cmp++; if (bus.o_err !== 1'b0)       begin n_bad++; $display("FAIL tmo_err_clear: got %b want 0", bus.o_err); end
    n_cmp++; if (bus.o_done !== 1'b1)      begin n_bad++; $display("FAIL empty_start_done: got %b want 1", bus.o_done); end
    step();
  endtask

  task automatic test_res_full();
    logic v; logic [3:0] ri; logic [15:0] rd; bit ok; bit seen;
    int good_issues = 0; int leaks = 0; int bad_res = 0;
    for (int k = 0; k < 8; k++) push_cmd(OP_ADD, 16'(k), 16'h0001);
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      wait_issue(ok);
      if (ok && bus.o_data_a === 16'(k)) good_issues++;
      step();
      respond(16'(k + 1));
      if (k == 0) push_cmd(OP_ADD, 16'h0100, 16'h0001);
    end
    n_cmp++; if (good_issues !== 8)        begin n_bad++; $display("FAIL full_issues: got %0d want 8", good_issues); end
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.o_in_valid !== 1'b0) leaks++;
      step();
    end
    n_cmp++; if (leaks !== 0)              begin n_bad++; $display("FAIL full_blocks_issue: got %0d issues want 0", leaks); end
    pop_res(v, ri, rd);
    n_cmp++; if (v !== 1'b1 || rd !== 16'h0001) begin n_bad++; $display("FAIL full_first_pop: got v=%b data=%h want 1/0001", v, rd); end
    #1;
    n_cmp++; if (bus.o_in_valid !== 1'b1 || bus.o_data_a !== 16'h0100) begin n_bad++; $display("FAIL full_ninth_issue: got v=%b a=%h want 1/0100", bus.o_in_valid, bus.o_data_a); end
    step();
    respond(16'h0101);
    wait_done(seen);
    n_cmp++; if (seen !== 1'b1)            begin n_bad++; $display("FAIL full_done: got %b want 1", seen); end
    for (int k = 1; k < 8; k++) begin
      pop_res(v, ri, rd);
      if (v !== 1'b1 || ri !== OP_ADD || rd !== 16'(k + 1)) bad_res++;
    end
    pop_res(v, ri, rd);
    if (v !== 1'b1 || rd !== 16'h0101) bad_res++;
    n_cmp++; if (bad_res !== 0)            begin n_bad++; $display("FAIL full_drain: got %0d bad entries want 0", bad_res); end
    n_cmp++; if (bus.o_res_valid !== 1'b0) begin n_bad++; $display("FAIL full_res_empty: got %b want 0", bus.o_res_valid); end
  endtask

  task automatic test_mid_group_reset();
    bit ok; int good_issues = 0; int stray = 0;
    for (int k = 0; k < 3; k++) push_cmd(OP_MATT, 16'h0020 + 16'(k), 16'h0000);
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      wait_issue(ok);
      if (ok && bus.o_data_a === 16'h0020 + 16'(k)) good_issues++;
      step();
    end
    n_cmp++; if (good_issues !== 3)        begin n_bad++; $display("FAIL grp_issues: got %0d want 3", good_issues); end
    for (int i = 0; i < 20; i++) begin
      if (bus.o_done || bus.o_err || bus.o_in_valid) stray++;
      step();
    end
    n_cmp++; if (stray !== 0)              begin n_bad++; $display("FAIL grp_wait_no_timeout: got %0d events want 0", stray); end
    n_cmp++; if (dut.state !== ST_ISSUE)   begin n_bad++; $display("FAIL grp_wait_state: got %0d want %0d", dut.state, ST_ISSUE); end
    bus.i_busy = 1'b1;
    push_cmd(OP_MATT, 16'h0030, 16'h0000);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.o_in_valid !== 1'b0 || bus.o_res_valid !== 1'b0 || bus.o_done !== 1'b0 || bus.o_err !== 1'b0)
      begin n_bad++; $display("FAIL grp_rst_flags: got in=%b res=%b done=%b err=%b want 0000", bus.o_in_valid, bus.o_res_valid, bus.o_done, bus.o_err); end
    n_cmp++; if (bus.o_cmd_ready !== 1'b1 || bus.o_inst !== 4'h0 || bus.o_data_a !== 16'h0 || bus.o_data_b !== 16'h0)
      begin n_bad++; $display("FAIL grp_rst_bus: got rdy=%b inst=%h a=%h b=%h want 1/0/0/0", bus.o_cmd_ready, bus.o_inst, bus.o_data_a, bus.o_data_b); end
    bus.i_busy = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.o_in_valid) stray++;
    end
    n_cmp++; if (stray !== 0)              begin n_bad++; $display("FAIL grp_rst_no_issue: got %0d issues want 0", stray); end
    pulse_start();
    n_cmp++; if (bus.o_done !== 1'b1 || bus.o_in_valid !== 1'b0) begin n_bad++; $display("FAIL grp_rst_discarded: got done=%b in=%b want 1/0", bus.o_done, bus.o_in_valid); end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_matt_group();
    test_busy();
    test_timeout();
    test_res_full();
    test_mid_group_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
